// File: rtl/pc_ctrl_if.sv
// Bus between pc_ctrl and the PC register, pipeline registers,
// instruction memory and the EX-stage resolution logic.
interface pc_ctrl_if;
    logic [31:0] i_pc_curr;
    logic [31:0] o_pc_next;
    logic        o_pc_stall;
    logic        o_ifid_stall;
    logic        o_ifid_flush;
    logic        o_idex_flush;
    logic        o_imem_req;
    logic        i_imem_ack;
    logic [4:0]  i_id_rs1;
    logic [4:0]  i_id_rs2;
    logic        i_id_uses_rs1;
    logic        i_id_uses_rs2;
    logic [4:0]  i_ex_rd;
    logic        i_ex_is_load;
    logic        i_ex_redirect;
    logic [31:0] i_ex_target;
    logic        i_trap;
    logic        o_fetch_fault;
    logic [1:0]  o_state;

    modport master (
        input  i_pc_curr, i_imem_ack,
        input  i_id_rs1, i_id_rs2, i_id_uses_rs1, i_id_uses_rs2,
        input  i_ex_rd, i_ex_is_load, i_ex_redirect, i_ex_target,
        input  i_trap,
        output o_pc_next, o_pc_stall, o_ifid_stall, o_ifid_flush,
        output o_idex_flush, o_imem_req, o_fetch_fault, o_state
    );

    modport slave (
        output i_pc_curr, i_imem_ack,
        output i_id_rs1, i_id_rs2, i_id_uses_rs1, i_id_uses_rs2,
        output i_ex_rd, i_ex_is_load, i_ex_redirect, i_ex_target,
        output i_trap,
        input  o_pc_next, o_pc_stall, o_ifid_stall, o_ifid_flush,
        input  o_idex_flush, o_imem_req, o_fetch_fault, o_state
    );
endinterface

// File: rtl/pc_ctrl.sv
// Next-PC sequencer and hazard controller for the RV32I pipeline.
// Fixed priority: trap/fault, redirect, load-use, fetch wait, sequential.
module pc_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int          IMEM_TIMEOUT = 16
) (
    input  logic      i_clk,
    input  logic      i_reset,
    pc_ctrl_if.master bus
);
    localparam int CW = (IMEM_TIMEOUT > 0) ? $clog2(IMEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST =
        (IMEM_TIMEOUT > 0) ? CW'(IMEM_TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] CMAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        WAIT  = 2'b10
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [CW-1:0] cnt_inc;
    logic          hazard;
    logic          fault;
    logic          rs1_hit;
    logic          rs2_hit;

    assign rs1_hit = bus.i_id_uses_rs1 && (bus.i_id_rs1 == bus.i_ex_rd);
    assign rs2_hit = bus.i_id_uses_rs2 && (bus.i_id_rs2 == bus.i_ex_rd);
    assign hazard  = bus.i_ex_is_load && (bus.i_ex_rd != 5'd0)
                     && (rs1_hit || rs2_hit);
    assign fault   = (IMEM_TIMEOUT != 0) && (cnt == LAST) && !bus.i_imem_ack;
    // Saturating so a disabled timeout can never wrap into a false match.
    assign cnt_inc = (cnt == CMAX) ? cnt : cnt + CW'(1);
    assign bus.o_state = state;

    always_comb begin
        bus.o_pc_next     = bus.i_pc_curr;
        bus.o_pc_stall    = 1'b0;
        bus.o_ifid_stall  = 1'b0;
        bus.o_ifid_flush  = 1'b0;
        bus.o_idex_flush  = 1'b0;
        bus.o_imem_req    = 1'b0;
        bus.o_fetch_fault = 1'b0;
        state_nx          = state;
        cnt_nx            = cnt;
        if (i_reset) begin
            bus.o_pc_next    = RESET_VECTOR;
            bus.o_pc_stall   = 1'b1;
            bus.o_ifid_flush = 1'b1;
            bus.o_idex_flush = 1'b1;
            state_nx         = IDLE;
            cnt_nx           = '0;
        end else if (state == IDLE) begin
            bus.o_pc_next    = RESET_VECTOR;
            bus.o_ifid_flush = 1'b1;
            bus.o_idex_flush = 1'b1;
            state_nx         = FETCH;
            cnt_nx           = '0;
        end else begin
            bus.o_imem_req = 1'b1;
            if (bus.i_trap || fault) begin
                bus.o_pc_next     = TRAP_VECTOR;
                bus.o_ifid_flush  = 1'b1;
                bus.o_idex_flush  = 1'b1;
                bus.o_fetch_fault = fault;
                state_nx          = FETCH;
                cnt_nx            = '0;
            end else if (bus.i_ex_redirect) begin
                bus.o_pc_next    = bus.i_ex_target;
                bus.o_ifid_flush = 1'b1;
                bus.o_idex_flush = 1'b1;
                state_nx         = FETCH;
                cnt_nx           = '0;
            end else if (hazard) begin
                bus.o_pc_stall   = 1'b1;
                bus.o_ifid_stall = 1'b1;
                bus.o_idex_flush = 1'b1;
                state_nx         = bus.i_imem_ack ? FETCH : WAIT;
                cnt_nx           = bus.i_imem_ack ? '0 : cnt_inc;
            end else if (!bus.i_imem_ack) begin
                bus.o_pc_stall   = 1'b1;
                bus.o_ifid_flush = 1'b1;
                state_nx         = WAIT;
                cnt_nx           = cnt_inc;
            end else begin
                bus.o_pc_next = bus.i_pc_curr + 32'd4;
                state_nx      = FETCH;
                cnt_nx        = '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end
endmodule

// File: tb/tb_pc_ctrl.sv
// Bench for pc_ctrl: three instances (timeout 16, 4, 0) on shared stimulus,
// directed tables plus random stimulus against a behavioural model.
module tb_pc_ctrl;
    localparam int TOS [3] = '{16, 4, 0};

    localparam logic [5:0] F_RST  = 6'b101100;
    localparam logic [5:0] F_IDLE = 6'b001100;
    localparam logic [5:0] F_SEQ  = 6'b000010;
    localparam logic [5:0] F_WAIT = 6'b101010;
    localparam logic [5:0] F_LU   = 6'b110110;
    localparam logic [5:0] F_RDR  = 6'b001110;
    localparam logic [5:0] F_FLT  = 6'b001111;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        ack;
    logic        trap;
    logic        redir;
    logic [31:0] tgt;
    logic        ld;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u1;
    logic        u2;
    logic [39:0] outv [3];

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    pc_ctrl_if bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int TO = (g == 0) ? 16 : (g == 1) ? 4 : 0;
        assign bus[g].i_pc_curr     = pc;
        assign bus[g].i_imem_ack    = ack;
        assign bus[g].i_id_rs1      = rs1;
        assign bus[g].i_id_rs2      = rs2;
        assign bus[g].i_id_uses_rs1 = u1;
        assign bus[g].i_id_uses_rs2 = u2;
        assign bus[g].i_ex_rd       = rd;
        assign bus[g].i_ex_is_load  = ld;
        assign bus[g].i_ex_redirect = redir;
        assign bus[g].i_ex_target   = tgt;
        assign bus[g].i_trap        = trap;
        assign outv[g] = {bus[g].o_pc_next, bus[g].o_pc_stall,
                          bus[g].o_ifid_stall, bus[g].o_ifid_flush,
                          bus[g].o_idex_flush, bus[g].o_imem_req,
                          bus[g].o_fetch_fault, bus[g].o_state};
        pc_ctrl #(.IMEM_TIMEOUT(TO)) u_dut (
            .i_clk   (clk),
            .i_reset (rst),
            .bus     (bus[g])
        );
    end

    typedef struct packed {
        logic        r;
        logic [31:0] p;
        logic        a;
        logic        t;
        logic        x;
        logic [31:0] tg;
        logic        l;
        logic [4:0]  d;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic        v1;
        logic        v2;
        logic [39:0] e;
    } vec_t;

    typedef struct packed {
        logic        idle;
        logic        waiting;
        logic [31:0] miss;
    } mst_t;

    function automatic vec_t mk(logic r, logic [31:0] p, logic a, logic t,
                                logic x, logic [31:0] tg, logic l,
                                logic [4:0] d, logic [4:0] s1,
                                logic [4:0] s2, logic v1, logic v2,
                                logic [31:0] nx, logic [5:0] fl,
                                logic [1:0] st);
        return '{r, p, a, t, x, tg, l, d, s1, s2, v1, v2, {nx, fl, st}};
    endfunction

    function automatic vec_t sv(logic r, logic [31:0] p, logic a,
                                logic [31:0] nx, logic [5:0] fl,
                                logic [1:0] st);
        return mk(r, p, a, 0, 0, 0, 0, 0, 0, 0, 0, 0, nx, fl, st);
    endfunction

    task automatic chk(input string nm, input logic [39:0] act,
                       input logic [39:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic apply(input vec_t v, input int k, input string nm,
                         input bit do_chk);
        rst = v.r; pc = v.p; ack = v.a; trap = v.t; redir = v.x;
        tgt = v.tg; ld = v.l; rd = v.d; rs1 = v.s1; rs2 = v.s2;
        u1 = v.v1; u2 = v.v2;
        #1;
        if (do_chk) chk(nm, outv[k], v.e);
        @(negedge clk);
    endtask

    task automatic run_tbl(input vec_t tb_q [$], input int k,
                           input string tag);
        foreach (tb_q[i]) apply(tb_q[i], k, $sformatf("%s_row%0d", tag, i), 1);
    endtask

    // Behavioural reference: expected outputs from the priority rules.
    function automatic logic [39:0] model(input mst_t s, input int to,
                                          output mst_t n);
        logic [31:0] nx;
        logic ps, is, ifl, idf, rq, flt, hz;
        logic [1:0] st;
        st = s.idle ? 2'd0 : (s.waiting ? 2'd2 : 2'd1);
        n = s; nx = pc;
        ps = 0; is = 0; ifl = 0; idf = 0; rq = 0; flt = 0;
        hz = ld && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        if (rst) begin
            nx = 0; ps = 1; ifl = 1; idf = 1;
            n = '{1'b1, 1'b0, 32'd0};
        end else if (s.idle) begin
            nx = 0; ifl = 1; idf = 1;
            n = '{1'b0, 1'b0, 32'd0};
        end else begin
            rq = 1;
            flt = (to != 0) && (int'(s.miss) == to - 1) && !ack;
            if (trap || flt) begin
                nx = 32'h100; ifl = 1; idf = 1;
                n = '{1'b0, 1'b0, 32'd0};
            end else if (redir) begin
                nx = tgt; ifl = 1; idf = 1;
                n = '{1'b0, 1'b0, 32'd0};
            end else if (hz) begin
                ps = 1; is = 1; idf = 1;
                n = ack ? '{1'b0, 1'b0, 32'd0} : '{1'b0, 1'b1, s.miss + 1};
            end else if (!ack) begin
                ps = 1; ifl = 1;
                n = '{1'b0, 1'b1, s.miss + 1};
            end else begin
                nx = pc + 32'd4;
                n = '{1'b0, 1'b0, 32'd0};
            end
        end
        return {nx, ps, is, ifl, idf, rq, flt, st};
    endfunction

    vec_t t16 [$];
    vec_t t4 [$];
    mst_t m [3];
    mst_t mn;
    logic [39:0] ev;
    int nf;
    int pct;

    initial begin
        t16 = '{
            sv(1, 0, 0, 0, F_RST, 0),
            sv(1, 0, 0, 0, F_RST, 0),
            sv(0, 0, 0, 0, F_IDLE, 0),
            sv(0, 0, 1, 32'h4, F_SEQ, 1),
            sv(0, 32'h4, 1, 32'h8, F_SEQ, 1),
            sv(0, 32'h8, 1, 32'hC, F_SEQ, 1),
            sv(0, 32'hC, 1, 32'h10, F_SEQ, 1),
            sv(0, 32'h10, 0, 32'h10, F_WAIT, 1),
            sv(0, 32'h10, 0, 32'h10, F_WAIT, 2),
            sv(0, 32'h10, 0, 32'h10, F_WAIT, 2),
            sv(0, 32'h10, 1, 32'h14, F_SEQ, 2),
            sv(0, 32'h14, 1, 32'h18, F_SEQ, 1),
            mk(0, 32'h20, 1, 0, 0, 0, 1, 5, 0, 5, 0, 1, 32'h20, F_LU, 1),
            sv(0, 32'h20, 1, 32'h24, F_SEQ, 1),
            mk(0, 32'h24, 1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 32'h28, F_SEQ, 1),
            mk(0, 32'h28, 0, 0, 0, 0, 1, 7, 7, 0, 1, 0, 32'h28, F_LU, 1),
            sv(0, 32'h28, 1, 32'h2C, F_SEQ, 2),
            mk(0, 32'h2C, 1, 0, 0, 0, 1, 3, 3, 4, 0, 1, 32'h30, F_SEQ, 1),
            mk(0, 32'h30, 1, 0, 1, 32'h80, 1, 5, 0, 5, 0, 1, 32'h80, F_RDR, 1),
            mk(0, 32'h80, 1, 1, 1, 32'h200, 0, 0, 0, 0, 0, 0, 32'h100, F_RDR, 1),
            sv(0, 32'h100, 0, 32'h100, F_WAIT, 1),
            sv(0, 32'h100, 0, 32'h100, F_WAIT, 2),
            mk(0, 32'h100, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100, F_RDR, 2),
            sv(0, 32'h100, 0, 32'h100, F_WAIT, 1),
            sv(0, 32'h100, 0, 32'h100, F_WAIT, 2),
            sv(1, 32'h100, 0, 0, F_RST, 2),
            mk(0, 32'h100, 0, 1, 1, 32'h300, 1, 5, 5, 5, 1, 1, 0, F_IDLE, 0),
            sv(0, 0, 1, 32'h4, F_SEQ, 1),
            sv(0, 32'hFFFF_FFFC, 1, 0, F_SEQ, 1),
            mk(0, 0, 1, 0, 1, 32'h44, 0, 0, 0, 0, 0, 0, 32'h44, F_RDR, 1)
        };
        t4 = '{
            sv(1, 32'h40, 0, 0, F_RST, 0),
            sv(0, 32'h40, 0, 0, F_IDLE, 0),
            sv(0, 32'h40, 0, 32'h40, F_WAIT, 1),
            sv(0, 32'h40, 0, 32'h40, F_WAIT, 2),
            sv(0, 32'h40, 0, 32'h40, F_WAIT, 2),
            sv(0, 32'h40, 0, 32'h100, F_FLT, 2),
            sv(0, 32'h40, 0, 32'h40, F_WAIT, 1),
            sv(0, 32'h40, 0, 32'h40, F_WAIT, 2),
            mk(0, 32'h40, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100, F_RDR, 2),
            sv(0, 32'h40, 0, 32'h40, F_WAIT, 1),
            sv(0, 32'h40, 0, 32'h40, F_WAIT, 2),
            sv(0, 32'h40, 0, 32'h40, F_WAIT, 2),
            sv(0, 32'h40, 0, 32'h100, F_FLT, 2),
            sv(0, 32'h40, 0, 32'h40, F_WAIT, 1),
            sv(0, 32'h40, 0, 32'h40, F_WAIT, 2),
            sv(0, 32'h40, 0, 32'h40, F_WAIT, 2),
            sv(1, 32'h40, 0, 0, F_RST, 2),
            sv(0, 32'h40, 0, 0, F_IDLE, 0)
        };

        @(negedge clk);
        apply(sv(1, 0, 0, 0, F_RST, 0), 0, "pre", 0);
        run_tbl(t16, 0, "t16");

        apply(sv(1, 32'h40, 0, 0, F_RST, 0), 1, "pre4", 0);
        run_tbl(t4, 1, "t4");

        // Disabled timeout: a long hung fetch must never fault.
        apply(sv(1, 0, 0, 0, F_RST, 0), 2, "pre0", 0);
        apply(sv(0, 0, 0, 0, F_IDLE, 0), 2, "t0_idle", 1);
        nf = 0;
        for (int i = 0; i < 100; i++) begin
            apply(sv(0, 32'h50, 0, 0, 0, 0), 2, "t0", 0);
            if (outv[2][2] !== 1'b0) nf++;
        end
        chk("t0_faults", 40'(nf), 40'd0);
        #1;
        chk("t0_state", {38'd0, outv[2][1:0]}, 40'd2);
        @(negedge clk);

        for (int k = 0; k < 3; k++) m[k] = '{1'b1, 1'b0, 32'd0};
        for (int c = 0; c < 600; c++) begin
            pct = ((c / 40) % 2 == 1) ? 15 : 80;
            rst = (c == 0) || ($urandom_range(0, 99) < 2);
            pc = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC
                 : ($urandom() & 32'hFFFF_FFFC);
            ack = $urandom_range(0, 99) < pct;
            trap = $urandom_range(0, 24) == 0;
            redir = $urandom_range(0, 9) == 0;
            tgt = $urandom() & 32'hFFFF_FFFC;
            ld = $urandom_range(0, 2) == 0;
            rd = 5'($urandom_range(0, 3));
            rs1 = 5'($urandom_range(0, 3));
            rs2 = 5'($urandom_range(0, 3));
            u1 = 1'($urandom_range(0, 1));
            u2 = 1'($urandom_range(0, 1));
            #1;
            for (int k = 0; k < 3; k++) begin
                ev = model(m[k], TOS[k], mn);
                m[k] = mn;
                if (c != 0) chk($sformatf("rnd%0d_c%0d", k, c), outv[k], ev);
            end
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
- Next-PC sequencer and hazard controller for the pipelined RV32I core.
- Drives the PC register through o_pc_next / o_pc_stall and issues stall/flush controls to the IF/ID and ID/EX pipeline registers.
- Arbitrates, by fixed priority, between trap entry, EX-stage redirect, load-use interlock, instruction-memory wait states and sequential fetch.
- Includes a fetch-timeout counter that converts a hung instruction fetch into a trap.

Parameters:
- RESET_VECTOR, 32'h0000_0000, first PC loaded after reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on trap or fetch fault.
- IMEM_TIMEOUT, 16, consecutive un-acked fetch cycles before a fetch fault; 0 disables the timeout.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_pc_curr  in  32  current PC from the PC register.
- o_pc_next  out  32  next PC to the PC register.
- o_pc_stall  out  1  hold the PC register.
- o_ifid_stall  out  1  hold IF/ID.
- o_ifid_flush  out  1  load a bubble into IF/ID.
- o_idex_flush  out  1  load a bubble into ID/EX.
- o_imem_req  out  1  fetch request at i_pc_curr.
- i_imem_ack  in  1  fetch data valid this cycle; only meaningful while o_imem_req=1.
- i_id_rs1, i_id_rs2  in  5 each  ID-stage source register numbers.
- i_id_uses_rs1, i_id_uses_rs2  in  1 each  ID instruction reads rs1 / rs2.
- i_ex_rd  in  5  EX-stage destination register.
- i_ex_is_load  in  1  EX instruction is a load.
- i_ex_redirect  in  1  taken branch or jump resolved in EX.
- i_ex_target  in  32  redirect target.
- i_trap  in  1  exception raised in EX.
- o_fetch_fault  out  1  one-cycle pulse when a fetch times out.
- o_state  out  2  FSM state: 00 IDLE, 01 FETCH, 10 WAIT.

Behaviour:
- State and the timeout counter are registered; all other outputs are combinational from state, counter and inputs.
- Reset (synchronous) sets state to IDLE and clears the counter.
  - Outputs while i_reset=1: o_pc_stall=1, o_ifid_flush=1, o_idex_flush=1, o_imem_req=0, o_pc_next=RESET_VECTOR, o_fetch_fault=0.
- IDLE, one cycle:
  - o_pc_next=RESET_VECTOR, o_pc_stall=0, both flushes=1, o_imem_req=0.
  - Next state: FETCH.
  - All of i_trap, i_ex_redirect, the load-use inputs and i_imem_ack are ignored.
- FETCH / WAIT: o_imem_req=1. The first matching priority below wins; outputs not named are 0.
  - P1, trap: i_trap=1, or fault = (IMEM_TIMEOUT!=0 && cnt==IMEM_TIMEOUT-1 && !i_imem_ack).
    - o_pc_next=TRAP_VECTOR, o_pc_stall=0, o_ifid_flush=1, o_idex_flush=1, o_fetch_fault=fault.
    - Counter clears; next state FETCH.
  - P2, redirect: i_ex_redirect=1.
    - o_pc_next=i_ex_target, o_pc_stall=0, both flushes=1.
    - Counter clears; next state FETCH. An ack in this cycle is discarded.
  - P3, load-use: i_ex_is_load && i_ex_rd!=0 && ((i_id_uses_rs1 && i_id_rs1==i_ex_rd) || (i_id_uses_rs2 && i_id_rs2==i_ex_rd)).
    - o_pc_stall=1, o_ifid_stall=1, o_idex_flush=1, o_pc_next=i_pc_curr.
    - Any ack is discarded; the same PC is refetched.
    - Counter: clears if i_imem_ack=1, else increments. State: FETCH if ack, else WAIT.
  - P4, fetch wait: i_imem_ack=0.
    - o_pc_stall=1, o_ifid_flush=1, o_pc_next=i_pc_curr.
    - Counter increments; next state WAIT.
  - P5, sequential: o_pc_next=i_pc_curr+32'd4 (mod 2^32; 32'hFFFF_FFFC wraps to 0), o_pc_stall=0.
    - Counter clears; next state FETCH.
- Counter:
  - Width is $clog2(IMEM_TIMEOUT+1); it saturates and never wraps.
  - It counts consecutive cycles with o_imem_req=1 && i_imem_ack=0 and resets to 0 on any ack, trap, redirect or reset.
- WAIT differs from FETCH only in o_state; the priority rules are identical.
- Asserting i_reset in any state or mid-wait returns to IDLE on the next edge, with no fault pulse.
- o_ifid_stall and o_ifid_flush are never both 1.
- The PC register samples o_pc_next only when o_pc_stall=0.

Test Plan:
- Reset and sequential fetch: i_reset high 2 cycles, then ack every cycle.
  - Expect o_state 00→01.
  - PC sequence 0x0, 0x4, 0x8, 0xC; no stalls or flushes after IDLE.
- Fetch wait: ack withheld 3 cycles at PC 0x10.
  - Expect o_pc_stall=1 and o_ifid_flush=1 for 3 cycles, o_state=10.
  - Ack on the 4th cycle → next PC 0x14, state 01.
- Load-use: EX load with rd=5, ID rs2=5, i_id_uses_rs2=1, at PC 0x20.
  - Expect a one-cycle o_pc_stall=1, o_ifid_stall=1, o_idex_flush=1; PC holds 0x20.
  - Repeat with rd=0 → no stall.
- Redirect vs load-use: i_ex_redirect=1 with target 0x80 and a load-use hazard in the same cycle.
  - Expect o_pc_next=0x80, o_pc_stall=0, both flushes=1, o_ifid_stall=0.
- Timeout: IMEM_TIMEOUT=4, no ack.
  - Expect o_fetch_fault pulse in the 4th un-acked cycle, o_pc_next=0x100, then state 01.
  - With IMEM_TIMEOUT=0: no fault after 100 cycles.
- Trap during wait, reset mid-wait, and wrap:
  - i_trap in WAIT → PC 0x100, counter cleared.
  - i_reset mid-wait → IDLE, o_fetch_fault=0.
  - PC 0xFFFF_FFFC with ack → o_pc_next=0x0.
